// File: rtl/clk_period_meter.sv
// clk_period_meter
// Measures the period of a slow, asynchronous clock (clkin) in system clock
// cycles. It raises locked when two successive periods agree within TOL, and
// raises lost when clkin stops toggling for TIMEOUT cycles.
// Legal parameter range: 2 <= TIMEOUT < 2**CNT_W.
module clk_period_meter #(
   parameter int          CNT_W   = 32,
   parameter int unsigned TIMEOUT = 200000,
   parameter int unsigned TOL     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clkin,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             locked,
   output logic             lost
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]   TOL_MAG     = (CNT_W+1)'(TOL);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOST    = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Synchronizer flops (p0, p1) and the history flop (p2) used for edge detection
   logic clkin_p0, clkin_p1, clkin_p2;
   logic rise;

   // Measurement registers and their next-state values
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] prev, prev_nxt;
   logic             prev_ok, prev_ok_nxt;
   logic [CNT_W-1:0] period_nxt;
   logic             vld_nxt;
   logic             locked_nxt;
   logic             lost_nxt;

   // Magnitude of a - b, computed one bit wider so that the subtraction cannot overflow
   function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
      logic signed [CNT_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d < 0) begin
         d = -d;
      end
      return $unsigned(d);
   endfunction

   // A rise is detected one cycle after the synchronized level goes high.
   // The fixed latency is the same for every edge, so it cancels out of the period.
   assign rise = clkin_p1 & ~clkin_p2;

   // Bring clkin into the clk domain and keep one cycle of history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clkin_p0 <= 1'b0;
         clkin_p1 <= 1'b0;
         clkin_p2 <= 1'b0;
      end else begin
         clkin_p0 <= clkin;
         clkin_p1 <= clkin_p0;
         clkin_p2 <= clkin_p1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus the counter, period, lock and loss updates
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      prev_nxt    = prev;
      prev_ok_nxt = prev_ok;
      period_nxt  = period;
      vld_nxt     = 1'b0;
      locked_nxt  = locked;
      lost_nxt    = lost;

      case (state)
         IDLE: begin
            // The first edge only starts the count; a full period has not been seen yet
            if (rise) begin
               state_nxt = MEASURE;
               cnt_nxt   = CNT_ONE;
            end
         end

         MEASURE: begin
            if (rise) begin
               // A rise takes priority over the timeout, even when both occur in the same cycle
               period_nxt  = cnt;
               vld_nxt     = 1'b1;
               cnt_nxt     = CNT_ONE;
               if (prev_ok) begin
                  locked_nxt = (abs_diff(cnt, prev) <= TOL_MAG);
               end
               prev_nxt    = cnt;
               prev_ok_nxt = 1'b1;
            end else if (cnt == TIMEOUT_CNT) begin
               // The count stops here; the timeout bound means it never wraps
               state_nxt   = LOST;
               lost_nxt    = 1'b1;
               locked_nxt  = 1'b0;
               prev_ok_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         LOST: begin
            // The count stays frozen; an edge restarts measurement without reporting a period
            if (rise) begin
               state_nxt = MEASURE;
               cnt_nxt   = CNT_ONE;
               lost_nxt  = 1'b0;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Measurement and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         prev       <= '0;
         prev_ok    <= 1'b0;
         period     <= '0;
         period_vld <= 1'b0;
         locked     <= 1'b0;
         lost       <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         prev       <= prev_nxt;
         prev_ok    <= prev_ok_nxt;
         period     <= period_nxt;
         period_vld <= vld_nxt;
         locked     <= locked_nxt;
         lost       <= lost_nxt;
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter.
// clkin is driven on falling edges of clk, so every measured period is an exact
// number of clk cycles. The outputs for a rise are sampled three falling edges
// after clkin goes high.
module tb_clk_period_meter;

   localparam int CNT_W = 32;

   logic             clk;
   logic             reset;
   logic             clkin;
   logic [CNT_W-1:0] period;
   logic             period_vld;
   logic             locked;
   logic             lost;

   int n_chk;
   int n_fail;
   int vld_count;
   int vld_snap;

   typedef struct {
      int   hi;
      int   lo;
      logic vld;
      int   per;
      logic lck;
      logic lst;
   } vec_t;

   vec_t tbl[13];

   clk_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (64),
      .TOL     (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clkin      (clkin),
      .period     (period),
      .period_vld (period_vld),
      .locked     (locked),
      .lost       (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count period_vld pulses so that silent windows can be verified
   always @(negedge clk) begin
      if (period_vld) vld_count <= vld_count + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Raise clkin, check the outputs produced by this rise, then check that the pulse lasts one cycle.
   // The task returns four falling edges after the raise, with clkin still high.
   task automatic rise_part(input string tag, input logic e_vld, input int e_per,
                            input logic e_lck, input logic e_lst);
      clkin = 1'b1;
      wait_neg(3);
      chk({tag, "_vld"},    64'(period_vld), 64'(e_vld));
      chk({tag, "_period"}, 64'(period),     64'(e_per));
      chk({tag, "_locked"}, 64'(locked),     64'(e_lck));
      chk({tag, "_lost"},   64'(lost),       64'(e_lst));
      wait_neg(1);
      chk({tag, "_vld_end"}, 64'(period_vld), 64'd0);
   endtask

   task automatic period_run(input string tag, input int hi, input int lo, input logic e_vld,
                             input int e_per, input logic e_lck, input logic e_lst);
      rise_part(tag, e_vld, e_per, e_lck, e_lst);
      wait_neg(hi - 4);
      clkin = 1'b0;
      wait_neg(lo);
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      vld_count = 0;
      vld_snap  = 0;
      clkin     = 1'b0;
      reset     = 1'b1;

      // Rows r0-r3: lock at 10. Rows r4-r6: step to 14 and relock.
      // Rows r7-r12: alternate between 10 and 11 cycles.
      tbl[0]  = '{5, 5, 1'b0,  0, 1'b0, 1'b0};
      tbl[1]  = '{5, 5, 1'b1, 10, 1'b0, 1'b0};
      tbl[2]  = '{5, 5, 1'b1, 10, 1'b1, 1'b0};
      tbl[3]  = '{5, 5, 1'b1, 10, 1'b1, 1'b0};
      tbl[4]  = '{7, 7, 1'b1, 10, 1'b1, 1'b0};
      tbl[5]  = '{7, 7, 1'b1, 14, 1'b0, 1'b0};
      tbl[6]  = '{7, 7, 1'b1, 14, 1'b1, 1'b0};
      tbl[7]  = '{5, 5, 1'b1, 14, 1'b1, 1'b0};
      tbl[8]  = '{5, 6, 1'b1, 10, 1'b0, 1'b0};
      tbl[9]  = '{5, 5, 1'b1, 11, 1'b1, 1'b0};
      tbl[10] = '{5, 6, 1'b1, 10, 1'b1, 1'b0};
      tbl[11] = '{5, 5, 1'b1, 11, 1'b1, 1'b0};
      tbl[12] = '{5, 5, 1'b1, 10, 1'b1, 1'b0};

      #1 reset = 1'b0;

      // Hold reset low while clkin toggles; all outputs must stay at zero
      for (int p = 0; p < 3; p++) begin
         clkin = 1'b1;
         wait_neg(5);
         clkin = 1'b0;
         wait_neg(5);
         chk("reset_hold", {29'd0, period, period_vld, locked, lost}, 64'd0);
      end
      reset = 1'b1;
      wait_neg(2);

      // Table: lock, step change, alternating jitter
      for (int r = 0; r < 13; r++) begin
         period_run($sformatf("row%0d", r), tbl[r].hi, tbl[r].lo,
                    tbl[r].vld, tbl[r].per, tbl[r].lck, tbl[r].lst);
      end

      // Stop clkin high after lock: lost must assert exactly 64 cycles after the last pulse
      rise_part("stop", 1'b1, 10, 1'b1, 1'b0);
      vld_snap = vld_count;
      wait_neg(62);
      chk("lost_early", 64'(lost), 64'd0);
      wait_neg(1);
      chk("lost_set",         64'(lost),      64'd1);
      chk("lost_locked",      64'(locked),    64'd0);
      chk("lost_period_hold", 64'(period),    64'd10);
      chk("lost_no_vld",      64'(vld_count), 64'(vld_snap));
      wait_neg(10);
      chk("lost_stays", 64'(lost), 64'd1);
      clkin = 1'b0;
      wait_neg(5);
      period_run("restart1", 5, 5, 1'b0, 10, 1'b0, 1'b0);
      period_run("restart2", 5, 5, 1'b1, 10, 1'b0, 1'b0);
      period_run("restart3", 5, 5, 1'b1, 10, 1'b1, 1'b0);

      // Asynchronous reset pulse in the middle of a locked period
      rise_part("pre_rst", 1'b1, 10, 1'b1, 1'b0);
      wait_neg(1);
      #2 reset = 1'b0;
      #1 chk("async_rst", {29'd0, period, period_vld, locked, lost}, 64'd0);
      clkin = 1'b0;
      wait_neg(3);
      chk("rst_held", {29'd0, period, period_vld, locked, lost}, 64'd0);
      reset = 1'b1;
      wait_neg(2);
      period_run("post_rst1", 5, 5, 1'b0,  0, 1'b0, 1'b0);
      period_run("post_rst2", 5, 5, 1'b1, 10, 1'b0, 1'b0);
      period_run("post_rst3", 5, 5, 1'b1, 10, 1'b1, 1'b0);

      // A rise that coincides with cnt==64 wins over the timeout
      period_run("pre64", 32, 32, 1'b1, 10, 1'b1, 1'b0);
      clkin = 1'b1;
      wait_neg(2);
      chk("edge64_lost_before", 64'(lost), 64'd0);
      wait_neg(1);
      chk("edge64_vld",    64'(period_vld), 64'd1);
      chk("edge64_period", 64'(period),     64'd64);
      chk("edge64_lost",   64'(lost),       64'd0);
      chk("edge64_locked", 64'(locked),     64'd0);
      wait_neg(1);
      chk("edge64_vld_end", 64'(period_vld), 64'd0);
      wait_neg(28);
      clkin = 1'b0;
      wait_neg(33);

      // A 65-cycle gap times out one cycle before the late rise arrives
      clkin = 1'b1;
      wait_neg(2);
      chk("edge65_lost",   64'(lost),   64'd1);
      chk("edge65_locked", 64'(locked), 64'd0);
      wait_neg(1);
      chk("edge65_recover", 64'(lost),       64'd0);
      chk("edge65_no_vld",  64'(period_vld), 64'd0);
      chk("edge65_period",  64'(period),     64'd64);
      wait_neg(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
